dac_spi_tx: RTL and testbench

//  Downstream consumer of the 12-bit triangular-wave sample stream. Serialises each

---
 rtl/dac_pkg.sv | 22 ++
 rtl/sclk_divider.sv | 38 +++
 rtl/dac_spi_tx.sv | 123 ++++++++++++
 tb/tb_dac_spi_tx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared definitions for the DAC SPI transmitter: frame geometry,
// config-bit positions and FSM state encoding.
package dac_pkg;
  localparam int DAC_DATA_W  = 12;
  localparam int DAC_FRAME_W = 16;

  // MCP4921 command nibble bit positions within the 16-bit frame
  localparam int CFG_AB_N_POS   = 15;
  localparam int CFG_BUF_POS    = 14;
  localparam int CFG_GA_N_POS   = 13;
  localparam int CFG_SHDN_N_POS = 12;

  typedef enum logic [1:0] {IDLE, SHIFT, CS_HOLD, LDAC} dac_state_t;

  // Assemble a write frame: command nibble above the 12-bit code
  function automatic logic [DAC_FRAME_W-1:0] build_frame(
    input logic [DAC_FRAME_W-DAC_DATA_W-1:0] cfg,
    input logic [DAC_DATA_W-1:0]             code
  );
    return {cfg, code};
  endfunction
endpackage

// File: rtl/sclk_divider.sv
// SCLK generator: counts CLK_DIV clk cycles per half-period, holds a
// registered sclk level and flags the edge that will raise/lower it.
module sclk_divider #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);
  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  // Strobes mark the cycle whose closing edge toggles sclk
  assign wrap     = en && (cnt == CW'(CLK_DIV - 1));
  assign rise_stb = wrap && !sclk;
  assign fall_stb = wrap &&  sclk;

  // Half-period counter and sclk level; clear parks sclk low
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (en) begin
      if (wrap) begin
        cnt  <= '0;
        sclk <= ~sclk;
      end else begin
        cnt  <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/dac_spi_tx.sv
// Serialises 12-bit samples into 16-bit MCP4921 write frames (SPI mode 0,
// MSB first), then strobes LDAC_n so the DAC updates once per frame.
module dac_spi_tx
  import dac_pkg::*;
#(
  parameter int                                 CLK_DIV    = 2,
  parameter logic [DAC_FRAME_W-DAC_DATA_W-1:0]  CFG_BITS   = 4'b0011,
  parameter int                                 LDAC_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DAC_DATA_W-1:0] sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  spi_sclk,
  output logic                  spi_mosi,
  output logic                  spi_cs_n,
  output logic                  dac_ldac_n,
  output logic                  busy
);
  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int LW = $clog2(LDAC_WIDTH + 1);

  dac_state_t             state;
  logic [DAC_FRAME_W-1:0] frame_sr;
  logic [DAC_FRAME_W-1:0] frame_new;
  logic [3:0]             bit_cnt;
  logic                   last_bit;
  logic [HW-1:0]          hold_cnt;
  logic [LW-1:0]          ldac_cnt;
  logic                   div_en;
  logic                   rise_stb;
  logic                   fall_stb;
  logic                   handshake;

  assign frame_new = build_frame(CFG_BITS, sample_in);
  assign handshake = sample_valid && sample_ready;
  // Divider only runs while shifting; held cleared otherwise so every
  // frame starts with a full low half-period
  assign div_en    = (state == SHIFT);

  sclk_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk      (clk),
    .rst      (rst),
    .clr      (!div_en),
    .en       (div_en),
    .sclk     (spi_sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // Frame FSM: capture, shift on sclk falls, CS hold, LDAC pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      frame_sr     <= '0;
      bit_cnt      <= '0;
      last_bit     <= 1'b0;
      hold_cnt     <= '0;
      ldac_cnt     <= '0;
      spi_mosi     <= 1'b0;
      spi_cs_n     <= 1'b1;
      dac_ldac_n   <= 1'b1;
      busy         <= 1'b0;
      sample_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sample_ready <= 1'b1;
          if (handshake) begin
            frame_sr     <= frame_new;
            spi_mosi     <= frame_new[DAC_FRAME_W-1];
            spi_cs_n     <= 1'b0;
            busy         <= 1'b1;
            sample_ready <= 1'b0;
            bit_cnt      <= 4'd15;
            last_bit     <= 1'b0;
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          // Rising edge consumes a bit; remember whether it was bit 0
          if (rise_stb) begin
            last_bit <= (bit_cnt == 4'd0);
            bit_cnt  <= bit_cnt - 1'b1;
          end
          // Falling edge starts the next bit, or closes the frame
          if (fall_stb) begin
            if (last_bit) begin
              spi_mosi <= 1'b0;
              hold_cnt <= HW'(CLK_DIV - 1);
              state    <= CS_HOLD;
            end else begin
              frame_sr <= frame_sr << 1;
              spi_mosi <= frame_sr[DAC_FRAME_W-2];
            end
          end
        end
        CS_HOLD: begin
          if (hold_cnt == '0) begin
            spi_cs_n   <= 1'b1;
            dac_ldac_n <= 1'b0;
            ldac_cnt   <= LW'(LDAC_WIDTH - 1);
            state      <= LDAC;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        LDAC: begin
          if (ldac_cnt == '0) begin
            dac_ldac_n   <= 1'b1;
            busy         <= 1'b0;
            sample_ready <= 1'b1;
            state        <= IDLE;
          end else begin
            ldac_cnt <= ldac_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: instance 0 uses defaults (CLK_DIV=2), instance 1
// uses CLK_DIV=1. A cycle-index model predicts every output each cycle;
// literal frame words, pulse lengths and spacings pin the model.
module tb_dac_spi_tx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] sample = '0;
  logic [1:0]  valid = '0;
  logic [1:0]  ready, sclk, mosi, cs, ldac, busy;

  int n_chk = 0, n_fail = 0, cyc = 0;

  always #5 clk = ~clk;

  dac_spi_tx dut0 (
    .clk(clk), .rst(rst), .sample_in(sample), .sample_valid(valid[0]),
    .sample_ready(ready[0]), .spi_sclk(sclk[0]), .spi_mosi(mosi[0]),
    .spi_cs_n(cs[0]), .dac_ldac_n(ldac[0]), .busy(busy[0])
  );

  dac_spi_tx #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .sample_in(sample), .sample_valid(valid[1]),
    .sample_ready(ready[1]), .spi_sclk(sclk[1]), .spi_mosi(mosi[1]),
    .spi_cs_n(cs[1]), .dac_ldac_n(ldac[1]), .busy(busy[1])
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int dval(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Expected {ready,busy,cs_n,ldac_n,sclk,mosi} for cycle kk of a frame
  // (kk<0: idle). Each bit is 2*d cycles: d low then d high.
  function automatic logic [5:0] expv(input int kk, input bit r,
                                      input logic [15:0] f, input int d);
    int j;
    if (kk < 0)        return {r, 5'b01100};
    if (kk <= 32 * d) begin
      j = kk - 1;
      return {4'b0101, ((j % (2 * d)) >= d), f[15 - j / (2 * d)]};
    end
    if (kk <= 33 * d)  return 6'b010100;
    return 6'b011000;
  endfunction

  // Model + monitor state
  int          k[2] = '{-1, -1};
  bit          rdy_m[2] = '{0, 0};
  logic [15:0] frm[2];
  bit          started = 0;
  logic [1:0]  pr_rdy = '0, pr_sclk = '0, pr_cs = '1, pr_ldac = '1;
  logic [15:0] cap[2];
  int          nrise[2], cslen[2], ldlen[2], pulses[2] = '{0, 0};
  int          hs_cnt[2] = '{0, 0}, hs_last[2], hs_prev[2];
  bit          hs_on[2] = '{0, 0};
  logic [15:0] exp0[$], exp1[$];
  int          exp_cs[2] = '{66, 33};
  int          exp_gap[2] = '{69, 36};

  always @(posedge clk) begin
    logic        rs;
    logic [1:0]  vs;
    logic [11:0] ss;
    logic [15:0] ef;
    cyc++;
    rs = rst; vs = valid; ss = sample;
    #1;
    if (rs) started = 1;
    for (int i = 0; i < 2; i++) begin
      // Model advance
      if (rs) begin
        k[i] = -1; rdy_m[i] = 0;
      end else if (k[i] < 0) begin
        if (rdy_m[i] && vs[i]) begin
          k[i] = 1; frm[i] = {4'b0011, ss};
        end else rdy_m[i] = 1;
      end else begin
        k[i]++;
        if (k[i] > 33 * dval(i) + 2) begin k[i] = -1; rdy_m[i] = 1; end
      end
      if (started)
        chk($sformatf("outs%0d", i),
            {ready[i], busy[i], cs[i], ldac[i], sclk[i], mosi[i]},
            expv(k[i], rdy_m[i], frm[i], dval(i)));

      // Literal monitors
      if (rs) begin
        cap[i] = '0; nrise[i] = 0; cslen[i] = 0; ldlen[i] = 0; hs_on[i] = 0;
      end else begin
        if (pr_rdy[i] && vs[i]) begin
          hs_prev[i] = hs_last[i]; hs_last[i] = cyc; hs_cnt[i]++; hs_on[i] = 1;
        end
        if (!pr_sclk[i] && sclk[i]) begin
          cap[i] = {cap[i][14:0], mosi[i]}; nrise[i]++;
        end
        if (!cs[i]) cslen[i]++;
        if (!pr_cs[i] && cs[i]) begin
          if (i == 0 && exp0.size() > 0)      ef = exp0.pop_front();
          else if (i == 1 && exp1.size() > 0) ef = exp1.pop_front();
          else ef = 16'hxxxx;
          if ($isunknown(ef)) chk($sformatf("frame%0d_unexpected", i), cap[i], 0);
          else                chk($sformatf("frame%0d", i), cap[i], ef);
          chk($sformatf("rises%0d", i), nrise[i], 16);
          chk($sformatf("cs_len%0d", i), cslen[i], exp_cs[i]);
          cap[i] = '0; nrise[i] = 0; cslen[i] = 0;
        end
        if (!ldac[i]) ldlen[i]++;
        if (pr_ldac[i] && !ldac[i]) pulses[i]++;
        if (!pr_ldac[i] && ldac[i]) begin
          chk($sformatf("ldac_len%0d", i), ldlen[i], 2);
          ldlen[i] = 0;
        end
        if (!pr_rdy[i] && ready[i] && hs_on[i]) begin
          chk($sformatf("ready_at%0d", i), cyc - hs_last[i] + 1, exp_gap[i]);
          hs_on[i] = 0;
        end
      end
    end
    pr_rdy = ready; pr_sclk = sclk; pr_cs = cs; pr_ldac = ldac;
  end

  task automatic wait_hs(input int i, input int n);
    int t = 0;
    do begin @(negedge clk); t++; end while (hs_cnt[i] <= n && t < 300);
    if (hs_cnt[i] <= n) chk($sformatf("hs_timeout%0d", i), 0, 1);
  endtask

  task automatic wait_idle(input int i);
    int t = 0;
    while (!ready[i] && t < 300) begin @(negedge clk); t++; end
    chk($sformatf("idle%0d", i), ready[i], 1);
  endtask

  initial begin
    int n;
    // 1: reset held 3 cycles with valid asserted
    valid[0] = 1'b1; sample = 12'hA5C;
    exp0.push_back(16'h3A5C);
    repeat (3) begin
      @(negedge clk);
      chk("reset_outs", {ready[0], busy[0], cs[0], ldac[0], sclk[0], mosi[0]}, 6'b001100);
    end
    n = hs_cnt[0];
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", ready[0], 1);
    chk("no_hs_in_reset", hs_cnt[0], n);
    // 2: frame 12'hA5C
    wait_hs(0, n);
    valid[0] = 1'b0;
    wait_idle(0);
    // 3: back-to-back 000 then FFF
    exp0.push_back(16'h3000); exp0.push_back(16'h3FFF);
    n = hs_cnt[0];
    sample = 12'h000; valid[0] = 1'b1;
    wait_hs(0, n);
    sample = 12'hFFF;
    wait_hs(0, n + 1);
    valid[0] = 1'b0;
    chk("b2b_spacing", hs_last[0] - hs_prev[0], 69);
    wait_idle(0);
    // 4: sample_in churns during the frame
    exp0.push_back(16'h3123);
    n = hs_cnt[0];
    sample = 12'h123; valid[0] = 1'b1;
    wait_hs(0, n);
    valid[0] = 1'b0;
    repeat (70) begin sample = 12'($urandom); @(negedge clk); end
    wait_idle(0);
    // 5: reset at cycle 20 aborts the frame
    n = hs_cnt[0];
    sample = 12'h555; valid[0] = 1'b1;
    wait_hs(0, n);
    valid[0] = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_outs", {ready[0], busy[0], cs[0], ldac[0], sclk[0], mosi[0]}, 6'b001100);
    exp0.push_back(16'h37FC);
    n = hs_cnt[0];
    sample = 12'h7FC; valid[0] = 1'b1;
    wait_hs(0, n);
    valid[0] = 1'b0;
    wait_idle(0);
    // 6: CLK_DIV=1 instance, two back-to-back frames
    exp1.push_back(16'h3802); exp1.push_back(16'h3802);
    n = hs_cnt[1];
    sample = 12'h802; valid[1] = 1'b1;
    wait_hs(1, n);
    wait_hs(1, n + 1);
    valid[1] = 1'b0;
    chk("div1_spacing", hs_last[1] - hs_prev[1], 36);
    wait_idle(1);
    repeat (5) @(negedge clk);
    chk("frames_left0", exp0.size(), 0);
    chk("frames_left1", exp1.size(), 0);
    chk("ldac_pulses0", pulses[0], 5);
    chk("ldac_pulses1", pulses[1], 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
